// File: rtl/ahb_usb_pkg.sv
// Shared AHB-Lite encodings, USB endpoint register map and the data-phase state type
// for the USB register-window manager.
package ahb_usb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [3:0] USB_REG_DATA0     = 4'h0;
  localparam logic [3:0] USB_REG_DATA1     = 4'h1;
  localparam logic [3:0] USB_REG_DATA2     = 4'h2;
  localparam logic [3:0] USB_REG_DATA3     = 4'h3;
  localparam logic [3:0] USB_REG_STATUS    = 4'h4;
  localparam logic [3:0] USB_REG_ERROR     = 4'h6;
  localparam logic [3:0] USB_REG_OCCUPANCY = 4'h8;
  localparam logic [3:0] USB_REG_TX_PACKET = 4'hC;
  localparam logic [3:0] USB_REG_FLUSH     = 4'hD;

  typedef enum logic [1:0] {DIDLE, DBUSY, ERR1, ERR2} dstate_t;

  // Size 3 is illegal and therefore always treated as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case ({1'b0, size})
      HSIZE_BYTE: misaligned = 1'b0;
      HSIZE_HALF: misaligned = addr_lo[0];
      HSIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering: replicates narrow write data across lanes and extracts/zero-extends
// narrow read data. Purely combinational, no latency, no backpressure.
module ahb_lane_steer
  import ahb_usb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  output logic [31:0] rdata
);

  always_comb begin
    hwdata = wdata;
    rdata  = hrdata;
    case ({1'b0, size})
      HSIZE_BYTE: begin
        hwdata = {4{wdata[7:0]}};
        rdata  = {24'd0, hrdata[8*addr_lo +: 8]};
      end
      HSIZE_HALF: begin
        hwdata = {2{wdata[15:0]}};
        rdata  = {16'd0, hrdata[16*addr_lo[1] +: 16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_usb_mgr.sv
// AHB-Lite manager for the USB register window: one address-phase and one data-phase slot,
// 1 transfer/cycle without waits, response one cycle after completion; optional AHB_MGR_TIMEOUT_EN.
module ahb_usb_mgr
  import ahb_usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [3:0]       cmd_addr,
  input  logic [1:0]       cmd_size,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_error,
  output logic             hsel,
  output logic [3:0]       haddr,
  output logic [1:0]       htrans,
  output logic [2:0]       hsize,
  output logic             hwrite,
  output logic [2:0]       hburst,
  output logic [31:0]      hwdata,
  input  logic [31:0]      hrdata,
  input  logic             hready,
  input  logic             hresp,
  output logic [CNT_W-1:0] xfer_count,
  output logic             timeout_flag
);

  dstate_t     state;
  logic        ap_vld, ap_write;
  logic [3:0]  ap_addr;
  logic [1:0]  ap_size;
  logic [31:0] ap_wdata;
  logic        dp_write;
  logic [1:0]  dp_addr_lo;
  logic [1:0]  dp_size;
  logic [31:0] dp_wdata;
  logic [31:0] rd_ext;
  logic        cmd_bad, cmd_take, handoff;

  assign cmd_bad = misaligned(cmd_size, cmd_addr[1:0]);
  // A reject answers next cycle, so it must wait until nothing else can answer first.
  assign cmd_ready = cmd_bad ? (!ap_vld && state == DIDLE)
                             : ((!ap_vld || hready) && state != ERR1);
  assign cmd_take  = cmd_valid && cmd_ready;
  assign handoff   = ap_vld && hready && state != ERR1;

  assign hsel   = ap_vld;
  assign htrans = (ap_vld && state != ERR1) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr  = ap_addr;
  assign hsize  = {1'b0, ap_size};
  assign hwrite = ap_write;
  assign hburst = HBURST_SINGLE;

  ahb_lane_steer u_steer (
    .size    (dp_size),
    .addr_lo (dp_addr_lo),
    .wdata   (dp_wdata),
    .hwdata  (hwdata),
    .hrdata  (hrdata),
    .rdata   (rd_ext)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= DIDLE;
      ap_vld     <= 1'b0;
      ap_write   <= 1'b0;
      ap_addr    <= '0;
      ap_size    <= '0;
      ap_wdata   <= '0;
      dp_write   <= 1'b0;
      dp_addr_lo <= '0;
      dp_size    <= '0;
      dp_wdata   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
      xfer_count <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (handoff) begin
        dp_write   <= ap_write;
        dp_addr_lo <= ap_addr[1:0];
        dp_size    <= ap_size;
        dp_wdata   <= ap_wdata;
      end
      if (cmd_take && !cmd_bad) begin
        ap_vld   <= 1'b1;
        ap_write <= cmd_write;
        ap_addr  <= cmd_addr;
        ap_size  <= cmd_size;
        ap_wdata <= cmd_write ? cmd_wdata : 32'd0;
      end else if (handoff) begin
        ap_vld <= 1'b0;
      end
      if (cmd_take && cmd_bad) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
      end
      case (state)
        DIDLE: if (handoff) state <= DBUSY;
        DBUSY: begin
          if (hready) begin
            rsp_valid  <= 1'b1;
            rsp_error  <= hresp;
            rsp_rdata  <= (dp_write || hresp) ? 32'd0 : rd_ext;
            xfer_count <= xfer_count + 1'b1;
            state      <= handoff ? DBUSY : DIDLE;
          end else if (hresp) begin
            state <= ERR1;
          end
        end
        // The pending address phase is cancelled here and reissued from ERR2.
        ERR1: begin
          if (hready && hresp) begin
            rsp_valid  <= 1'b1;
            rsp_error  <= 1'b1;
            rsp_rdata  <= '0;
            xfer_count <= xfer_count + 1'b1;
            state      <= ERR2;
          end
        end
        ERR2: state <= handoff ? DBUSY : DIDLE;
        default: state <= DIDLE;
      endcase
    end
  end

`ifdef AHB_MGR_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0] wait_cnt;

  // Only flags a stuck subordinate; the transfer itself keeps waiting.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else if (handoff) begin
      wait_cnt <= '0;
    end else if (state == DBUSY && !hready) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
      if (32'(wait_cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES)) timeout_flag <= 1'b1;
    end
  end
`else
  // TIMEOUT_CYCLES is inert in this build.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_inert
  end
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_usb_mgr.sv
// Directed bench for ahb_usb_mgr: drives commands and a scripted subordinate cycle by cycle.
module tb_ahb_usb_mgr;
  import ahb_usb_pkg::*;

`ifdef AHB_MGR_TIMEOUT_EN
  localparam logic [31:0] EXP_TO = 32'd1;
`else
  localparam logic [31:0] EXP_TO = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        hsel, hwrite, hready, hresp;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata, hrdata;
  logic [15:0] xfer_count;
  logic        timeout_flag;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic        b2b_w  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]  b2b_s  [4] = '{2'd2, 2'd0, 2'd1, 2'd2};
  logic [31:0] b2b_hr [8] = '{32'h0, 32'h0, 32'h0, 32'h44332211, 32'hBEEF1234,
                              32'hCAFEF00D, 32'h0, 32'h0};
  logic [31:0] b2b_rd [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h44, 32'hBEEF,
                              32'hCAFEF00D, 32'h0};
  logic [3:0]  b2b_a  [4];

  ahb_usb_mgr #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .xfer_count(xfer_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] a, input logic [1:0] s,
                       input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 4'h0;
    cmd_size  = 2'd0;
    cmd_wdata = 32'h0;
  endtask

  initial begin
    b2b_a = '{USB_REG_DATA0, USB_REG_DATA3, USB_REG_ERROR, USB_REG_OCCUPANCY};
    n_rst = 1'b0;
    idle();
    hrdata = 32'h0;
    hready = 1'b1;
    hresp  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_hsel", 32'(hsel), 32'd0);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_hburst", 32'(hburst), 32'd0);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    n_rst = 1'b1;

    // Word write, zero wait states
    tick(); drive(1'b1, USB_REG_DATA0, 2'd2, 32'hDEADBEEF); #1;
    chk("t1_ready", 32'(cmd_ready), 32'd1);
    tick(); idle(); #1;
    chk("t1_htrans", 32'(htrans), 32'h2);
    chk("t1_hwrite", 32'(hwrite), 32'd1);
    chk("t1_hsize", 32'(hsize), 32'd2);
    tick(); #1;
    chk("t1_htrans_idle", 32'(htrans), 32'd0);
    chk("t1_hwdata", hwdata, 32'hDEADBEEF);
    chk("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    tick(); #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_error", 32'(rsp_error), 32'd0);
    chk("t1_xfer_count", 32'(xfer_count), 32'd1);
    tick(); #1;
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);

    // Byte read at offset 2 with two wait states
    tick(); drive(1'b0, USB_REG_DATA2, 2'd0, 32'h0); #1;
    tick(); idle(); #1;
    chk("t2_htrans", 32'(htrans), 32'h2);
    chk("t2_haddr", 32'(haddr), 32'h2);
    chk("t2_hsize", 32'(hsize), 32'd0);
    tick(); hready = 1'b0; #1;
    chk("t2_wait1_rsp", 32'(rsp_valid), 32'd0);
    tick(); #1;
    chk("t2_wait2_htrans", 32'(htrans), 32'd0);
    tick(); hready = 1'b1; hrdata = 32'h00AB0000; #1;
    chk("t2_final_rsp", 32'(rsp_valid), 32'd0);
    tick(); hrdata = 32'h0; #1;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_rdata", rsp_rdata, 32'h000000AB);
    chk("t2_xfer_count", 32'(xfer_count), 32'd2);
    tick(); #1;
    chk("t2_rsp_pulse", 32'(rsp_valid), 32'd0);

    // Four back-to-back commands
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 4) drive(b2b_w[i], b2b_a[i], b2b_s[i], 32'h11111111);
      else idle();
      hrdata = b2b_hr[i];
      #1;
      if (i < 4) chk("b2b_ready", 32'(cmd_ready), 32'd1);
      chk("b2b_htrans", 32'(htrans), (i >= 1 && i <= 4) ? 32'h2 : 32'h0);
      if (i >= 1 && i <= 4) chk("b2b_haddr", 32'(haddr), 32'(b2b_a[i-1]));
      if (i == 2) chk("b2b_hwdata", hwdata, 32'h11111111);
      chk("b2b_rsp_valid", 32'(rsp_valid), (i >= 3 && i <= 6) ? 32'd1 : 32'd0);
      if (i >= 3 && i <= 6) chk("b2b_rsp_rdata", rsp_rdata, b2b_rd[i]);
    end
    chk("b2b_xfer_count", 32'(xfer_count), 32'd6);

    // ERROR response on a byte read with a second command queued
    tick(); drive(1'b0, 4'h9, 2'd0, 32'h0); #1;
    tick(); drive(1'b0, USB_REG_STATUS, 2'd2, 32'h0); #1;
    chk("t4_haddr_first", 32'(haddr), 32'h9);
    tick(); idle(); hready = 1'b0; hresp = 1'b1; #1;
    chk("t4_haddr_second", 32'(haddr), 32'h4);
    tick(); hready = 1'b1; hresp = 1'b1; #1;
    chk("t4_err1_htrans", 32'(htrans), 32'd0);
    chk("t4_err1_ready", 32'(cmd_ready), 32'd0);
    tick(); hresp = 1'b0; #1;
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_rsp_error", 32'(rsp_error), 32'd1);
    chk("t4_rsp_rdata", rsp_rdata, 32'd0);
    chk("t4_reissue_htrans", 32'(htrans), 32'h2);
    chk("t4_reissue_haddr", 32'(haddr), 32'h4);
    chk("t4_xfer_count", 32'(xfer_count), 32'd7);
    tick(); hrdata = 32'h0000005A; #1;
    chk("t4_dp_rsp", 32'(rsp_valid), 32'd0);
    tick(); hrdata = 32'h0; #1;
    chk("t4_second_valid", 32'(rsp_valid), 32'd1);
    chk("t4_second_error", 32'(rsp_error), 32'd0);
    chk("t4_second_rdata", rsp_rdata, 32'h5A);
    chk("t4_second_count", 32'(xfer_count), 32'd8);

    // Misaligned halfword write is rejected locally
    tick(); drive(1'b1, USB_REG_DATA1, 2'd1, 32'h5555); #1;
    chk("t5_ready", 32'(cmd_ready), 32'd1);
    tick(); idle(); #1;
    chk("t5_hsel", 32'(hsel), 32'd0);
    chk("t5_htrans", 32'(htrans), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t5_rsp_error", 32'(rsp_error), 32'd1);
    chk("t5_xfer_count", 32'(xfer_count), 32'd8);

    // Halfword write lane replication, then a size-3 reject held off behind it
    tick(); drive(1'b1, USB_REG_DATA2, 2'd1, 32'hAAAA1234); #1;
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    tick(); drive(1'b1, USB_REG_FLUSH, 2'd3, 32'h0); #1;
    chk("t6_rej_stall_ap", 32'(cmd_ready), 32'd0);
    chk("t6_htrans", 32'(htrans), 32'h2);
    tick(); #1;
    chk("t6_hwdata", hwdata, 32'h12341234);
    chk("t6_rej_stall_dp", 32'(cmd_ready), 32'd0);
    tick(); #1;
    chk("t6_hw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t6_hw_rsp_error", 32'(rsp_error), 32'd0);
    chk("t6_rej_ready", 32'(cmd_ready), 32'd1);
    chk("t6_xfer_count", 32'(xfer_count), 32'd9);
    tick(); idle(); #1;
    chk("t6_rej_valid", 32'(rsp_valid), 32'd1);
    chk("t6_rej_error", 32'(rsp_error), 32'd1);
    chk("t6_rej_htrans", 32'(htrans), 32'd0);

    // Long stall: six wait states on a word read
    tick(); drive(1'b0, USB_REG_TX_PACKET, 2'd2, 32'h0); #1;
    tick(); idle(); #1;
    for (int k = 1; k <= 6; k++) begin
      tick(); hready = 1'b0; #1;
      if (k == 1) chk("t7_flag_early", 32'(timeout_flag), 32'd0);
      if (k == 5) chk("t7_flag_after4", 32'(timeout_flag), EXP_TO);
    end
    tick(); hready = 1'b1; hrdata = 32'h12345678; #1;
    tick(); hrdata = 32'h0; #1;
    chk("t7_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t7_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("t7_flag_sticky", 32'(timeout_flag), EXP_TO);
    chk("t7_xfer_count", 32'(xfer_count), 32'd10);

    // Reset in the middle of a stalled data phase
    tick(); drive(1'b1, USB_REG_DATA0, 2'd2, 32'hCAFEBABE); #1;
    tick(); idle(); #1;
    tick(); hready = 1'b0; #1;
    chk("t8_pre_hwdata", hwdata, 32'hCAFEBABE);
    n_rst = 1'b0; #1;
    chk("t8_hsel", 32'(hsel), 32'd0);
    chk("t8_htrans", 32'(htrans), 32'd0);
    chk("t8_hwdata", hwdata, 32'd0);
    chk("t8_xfer_count", 32'(xfer_count), 32'd0);
    chk("t8_timeout", 32'(timeout_flag), 32'd0);
    chk("t8_cmd_ready", 32'(cmd_ready), 32'd1);
    hready = 1'b1;
    #2;
    n_rst = 1'b1;
    tick(); #1;
    chk("t8_no_rsp", 32'(rsp_valid), 32'd0);
    tick(); #1;
    chk("t8_still_no_rsp", 32'(rsp_valid), 32'd0);
    chk("t8_bus_idle", 32'(htrans), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
